// File: rtl/ch_list_merge.sv
// Merges every known cluster-head ID into each neighbour's CH-ID row in shared memory, seeding a Q-value per append.
// Reads take 2 cycles, writes 1; start/busy/done handshake, start ignored while busy or in the done cycle.
module ch_list_merge #(
  parameter int                    WORD_WIDTH  = 16,
  parameter int                    ADDR_WIDTH  = 11,
  parameter int                    ADDR_STRIDE = 2,
  parameter int                    MAX_NBRS    = 16,
  parameter int                    MAX_KCH     = 16,
  parameter int                    MAX_SLOTS   = 8,
  parameter logic [ADDR_WIDTH-1:0] NCNT_ADDR   = 11'h274,
  parameter logic [ADDR_WIDTH-1:0] KCNT_ADDR   = 11'h272,
  parameter logic [ADDR_WIDTH-1:0] KCH_BASE    = 11'h012,
  parameter logic [ADDR_WIDTH-1:0] HOPS_BASE   = 11'h032,
  parameter logic [ADDR_WIDTH-1:0] CCNT_BASE   = 11'h278,
  parameter logic [ADDR_WIDTH-1:0] CHID_BASE   = 11'h172,
  parameter logic [ADDR_WIDTH-1:0] QV_BASE     = 11'h052,
  parameter int                    Q_MODE      = 0,
  parameter logic [WORD_WIDTH-1:0] QV_INIT     = 16'h0100,
  parameter logic [WORD_WIDTH-1:0] HOP_PENALTY = 16'h0010
) (
  input  logic                  clock,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WORD_WIDTH-1:0] data_in,
  output logic [ADDR_WIDTH-1:0] address,
  output logic                  wr_en,
  output logic [WORD_WIDTH-1:0] data_out,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [7:0]            appended
);

  localparam int NW = $clog2(MAX_NBRS + 1);
  localparam int KW = $clog2(MAX_KCH + 1);
  localparam int SW = $clog2(MAX_SLOTS + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_RD_NCNT, S_RD_KCNT, S_RD_KCH, S_RD_HOPS, S_RD_CCNT, S_RD_CHID,
    S_APPEND, S_WR_CHID, S_WR_QV, S_WR_CCNT, S_NEXT, S_DONE
  } state_t;

  state_t                r_state;
  logic                  r_ph;
  logic [NW-1:0]         r_ncnt, r_i;
  logic [KW-1:0]         r_kcnt, r_j;
  logic [SW-1:0]         r_ccnt, r_k;
  logic [WORD_WIDTH-1:0] r_kid, r_hops;

  function automatic logic [ADDR_WIDTH-1:0] f_lin(input logic [ADDR_WIDTH-1:0] base,
                                                  input logic [31:0] idx);
    return base + ADDR_WIDTH'(idx * ADDR_STRIDE);
  endfunction

  function automatic logic [31:0] f_slot(input logic [31:0] row, input logic [31:0] slot);
    return row * MAX_SLOTS + slot;
  endfunction

  logic                    w_is_rd;
  logic                    w_nc_big, w_kc_big, w_cc_big;
  logic [NW-1:0]           w_nc, w_i_nxt;
  logic [KW-1:0]           w_kc, w_j_nxt;
  logic [SW-1:0]           w_cc, w_k_nxt;
  logic [2*WORD_WIDTH-1:0] w_prod;
  logic [WORD_WIDTH-1:0]   w_seed;

  assign w_is_rd  = r_state inside {S_RD_NCNT, S_RD_KCNT, S_RD_KCH, S_RD_HOPS, S_RD_CCNT, S_RD_CHID};
  assign w_nc_big = data_in > WORD_WIDTH'(MAX_NBRS);
  assign w_kc_big = data_in > WORD_WIDTH'(MAX_KCH);
  assign w_cc_big = data_in > WORD_WIDTH'(MAX_SLOTS);
  assign w_nc     = w_nc_big ? NW'(MAX_NBRS)  : NW'(data_in);
  assign w_kc     = w_kc_big ? KW'(MAX_KCH)   : KW'(data_in);
  assign w_cc     = w_cc_big ? SW'(MAX_SLOTS) : SW'(data_in);
  assign w_i_nxt  = r_i + NW'(1);
  assign w_j_nxt  = r_j + KW'(1);
  assign w_k_nxt  = r_k + SW'(1);

  // Full-width product so a large hop count saturates instead of wrapping.
  assign w_prod = {{WORD_WIDTH{1'b0}}, r_hops} * {{WORD_WIDTH{1'b0}}, HOP_PENALTY};
  assign w_seed = (Q_MODE == 0) ? QV_INIT :
                  (w_prod >= {{WORD_WIDTH{1'b0}}, QV_INIT}) ? '0 :
                  QV_INIT - w_prod[WORD_WIDTH-1:0];

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_ph     <= 1'b0;
      r_ncnt   <= '0;
      r_kcnt   <= '0;
      r_ccnt   <= '0;
      r_i      <= '0;
      r_j      <= '0;
      r_k      <= '0;
      r_kid    <= '0;
      r_hops   <= '0;
      address  <= '0;
      wr_en    <= 1'b0;
      data_out <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
      appended <= '0;
    end else begin
      wr_en <= 1'b0;
      done  <= 1'b0;
      if (w_is_rd && !r_ph) begin
        r_ph <= 1'b1;
      end else begin
        r_ph <= 1'b0;
        case (r_state)
          S_IDLE: if (start && !done) begin
            overflow <= 1'b0;
            appended <= '0;
            busy     <= 1'b1;
            r_i      <= '0;
            r_j      <= '0;
            r_k      <= '0;
            address  <= NCNT_ADDR;
            r_state  <= S_RD_NCNT;
          end
          S_RD_NCNT: begin
            r_ncnt  <= w_nc;
            if (w_nc_big) overflow <= 1'b1;
            address <= KCNT_ADDR;
            r_state <= S_RD_KCNT;
          end
          S_RD_KCNT: begin
            r_kcnt <= w_kc;
            if (w_kc_big) overflow <= 1'b1;
            if (r_ncnt == '0 || w_kc == '0) begin
              r_state <= S_DONE;
            end else begin
              address <= KCH_BASE;
              r_state <= S_RD_KCH;
            end
          end
          S_RD_KCH: begin
            r_kid   <= data_in;
            address <= f_lin(HOPS_BASE, 32'(r_j));
            r_state <= S_RD_HOPS;
          end
          S_RD_HOPS: begin
            r_hops  <= data_in;
            address <= f_lin(CCNT_BASE, 32'(r_i));
            r_state <= S_RD_CCNT;
          end
          S_RD_CCNT: begin
            r_ccnt <= w_cc;
            r_k    <= '0;
            if (w_cc_big) overflow <= 1'b1;
            if (w_cc == '0) begin
              r_state <= S_APPEND;
            end else begin
              address <= f_lin(CHID_BASE, f_slot(32'(r_i), 32'd0));
              r_state <= S_RD_CHID;
            end
          end
          S_RD_CHID: begin
            if (data_in == r_kid) begin
              r_state <= S_NEXT;
            end else if (w_k_nxt < r_ccnt) begin
              r_k     <= w_k_nxt;
              address <= f_lin(CHID_BASE, f_slot(32'(r_i), 32'(w_k_nxt)));
            end else begin
              r_state <= S_APPEND;
            end
          end
          S_APPEND: begin
            if (r_ccnt == SW'(MAX_SLOTS)) begin
              overflow <= 1'b1;
              r_state  <= S_NEXT;
            end else begin
              address  <= f_lin(CHID_BASE, f_slot(32'(r_i), 32'(r_ccnt)));
              data_out <= r_kid;
              wr_en    <= 1'b1;
              r_state  <= S_WR_CHID;
            end
          end
          S_WR_CHID: begin
            address  <= f_lin(QV_BASE, f_slot(32'(r_i), 32'(r_ccnt)));
            data_out <= w_seed;
            wr_en    <= 1'b1;
            r_state  <= S_WR_QV;
          end
          S_WR_QV: begin
            address  <= f_lin(CCNT_BASE, 32'(r_i));
            data_out <= WORD_WIDTH'(r_ccnt) + WORD_WIDTH'(1);
            wr_en    <= 1'b1;
            r_state  <= S_WR_CCNT;
          end
          S_WR_CCNT: begin
            if (appended != 8'hFF) appended <= appended + 8'd1;
            r_state <= S_NEXT;
          end
          S_NEXT: begin
            r_k <= '0;
            if (w_i_nxt == r_ncnt) begin
              r_i <= '0;
              if (w_j_nxt == r_kcnt) begin
                r_state <= S_DONE;
              end else begin
                r_j     <= w_j_nxt;
                address <= f_lin(KCH_BASE, 32'(w_j_nxt));
                r_state <= S_RD_KCH;
              end
            end else begin
              r_i     <= w_i_nxt;
              address <= f_lin(CCNT_BASE, 32'(w_i_nxt));
              r_state <= S_RD_CCNT;
            end
          end
          S_DONE: begin
            done    <= 1'b1;
            busy    <= 1'b0;
            r_state <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ch_list_merge.sv
// Bench for ch_list_merge: two instances (Q_MODE 0 and 1) on private memories, checked against a list-level model.
module tb_ch_list_merge;

  localparam logic [10:0] NCNT = 11'h274;
  localparam logic [10:0] KCNT = 11'h272;
  localparam int          BIG  = 1 << 30;
  localparam int          LIM  = 20000;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        rst, start;
  logic [15:0] din0, din1, dout0, dout1;
  logic [10:0] addr0, addr1;
  logic        we0, we1, busy0, busy1, done0, done1, ovf0, ovf1;
  logic [7:0]  app0, app1;

  ch_list_merge #(.Q_MODE(0)) u_dut0 (
    .clock(clock), .rst(rst), .start(start), .data_in(din0), .address(addr0), .wr_en(we0),
    .data_out(dout0), .busy(busy0), .done(done0), .overflow(ovf0), .appended(app0));
  ch_list_merge #(.Q_MODE(1)) u_dut1 (
    .clock(clock), .rst(rst), .start(start), .data_in(din1), .address(addr1), .wr_en(we1),
    .data_out(dout1), .busy(busy1), .done(done1), .overflow(ovf1), .appended(app1));

  logic [15:0] mem0 [0:2047];
  logic [15:0] mem1 [0:2047];
  logic [15:0] ref0 [0:2047];
  logic [15:0] ref1 [0:2047];
  logic        tb_we, tb_clr;
  logic [10:0] tb_a;
  logic [15:0] tb_d;

  always @(posedge clock) begin
    din0 <= mem0[addr0];
    din1 <= mem1[addr1];
    if (tb_clr) begin
      for (int a = 0; a < 2048; a++) begin
        mem0[a] <= '0;
        mem1[a] <= '0;
      end
    end else if (tb_we) begin
      mem0[tb_a] <= tb_d;
      mem1[tb_a] <= tb_d;
    end else begin
      if (we0) mem0[addr0] <= dout0;
      if (we1) mem1[addr1] <= dout1;
    end
  end

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [10:0] a_kch(input int j);  return 11'(32'h012 + 2 * j); endfunction
  function automatic logic [10:0] a_hops(input int j); return 11'(32'h032 + 2 * j); endfunction
  function automatic logic [10:0] a_ccnt(input int i); return 11'(32'h278 + 2 * i); endfunction
  function automatic logic [10:0] a_chid(input int i, input int k); return 11'(32'h172 + 2 * (8 * i + k)); endfunction
  function automatic logic [10:0] a_qv(input int i, input int k);   return 11'(32'h052 + 2 * (8 * i + k)); endfunction

  function automatic int ndiff(input bit sel);
    int n = 0;
    for (int a = 0; a < 2048; a++)
      if (sel ? (mem1[a] !== ref1[a]) : (mem0[a] !== ref0[a])) n++;
    return n;
  endfunction

  task automatic put(input logic [10:0] a, input logic [15:0] d);
    tb_a = a; tb_d = d; tb_we = 1'b1;
    @(posedge clock); #1;
    tb_we = 1'b0;
    ref0[a] = d;
    ref1[a] = d;
  endtask

  task automatic clr_mem;
    tb_clr = 1'b1;
    @(posedge clock); #1;
    tb_clr = 1'b0;
    for (int a = 0; a < 2048; a++) begin
      ref0[a] = '0;
      ref1[a] = '0;
    end
  endtask

  // Model: visit every (known CH, neighbour) pair j-major and append whatever is missing; stops after wlimit writes.
  task automatic ref_run(input int wlimit, output int e_app, output logic e_ovf);
    int nc, kc, c, wr;
    logic [15:0] id, s1;
    longint p;
    bit found;
    e_app = 0; e_ovf = 1'b0; wr = 0;
    nc = int'(ref0[NCNT]);
    kc = int'(ref0[KCNT]);
    if (nc > 16) begin nc = 16; e_ovf = 1'b1; end
    if (kc > 16) begin kc = 16; e_ovf = 1'b1; end
    if (nc == 0 || kc == 0) return;
    for (int j = 0; j < kc; j++) begin
      id = ref0[a_kch(j)];
      p  = longint'(ref0[a_hops(j)]) * 16;
      s1 = (p >= 256) ? 16'h0000 : 16'(256 - p);
      for (int i = 0; i < nc; i++) begin
        c = int'(ref0[a_ccnt(i)]);
        if (c > 8) begin c = 8; e_ovf = 1'b1; end
        found = 1'b0;
        for (int k = 0; k < c; k++) if (ref0[a_chid(i, k)] == id) found = 1'b1;
        if (!found) begin
          if (c == 8) begin
            e_ovf = 1'b1;
          end else begin
            if (wr == wlimit) return;
            ref0[a_chid(i, c)] = id; ref1[a_chid(i, c)] = id; wr++;
            if (wr == wlimit) return;
            ref0[a_qv(i, c)] = 16'h0100; ref1[a_qv(i, c)] = s1; wr++;
            if (wr == wlimit) return;
            ref0[a_ccnt(i)] = 16'(c + 1); ref1[a_ccnt(i)] = 16'(c + 1); wr++;
            if (e_app < 255) e_app++;
          end
        end
      end
    end
  endtask

  // Pulses start, re-pulses it mid-run (must be ignored), counts cycles to done and write cycles.
  task automatic run(output int cyc, output int nwr);
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    cyc = 1; nwr = 0;
    chk("busy_rise", busy0, 1);
    while (done0 !== 1'b1 && cyc < LIM) begin
      if (we0) nwr++;
      start = (cyc == 3);
      @(posedge clock); #1;
      cyc++;
    end
    start = 1'b0;
    chk("run_timeout", cyc < LIM, 1);
    chk("done_sync", done1, 1);
  endtask

  task automatic verify(input int e_app, input logic e_ovf, input int nwr);
    chk("appended0", app0, e_app);
    chk("appended1", app1, e_app);
    chk("overflow0", ovf0, e_ovf);
    chk("overflow1", ovf1, e_ovf);
    chk("write_cycles", nwr, 3 * e_app);
    chk("mem0_diffs", ndiff(1'b0), 0);
    chk("mem1_diffs", ndiff(1'b1), 0);
    @(posedge clock); #1;
    chk("done_pulse", done0, 0);
    chk("busy_low", busy0, 0);
  endtask

  task automatic setup_t2(input logic [15:0] hops);
    clr_mem;
    put(NCNT, 16'd2); put(KCNT, 16'd1);
    put(a_kch(0), 16'd5); put(a_hops(0), hops);
    put(a_ccnt(0), 16'd1); put(a_chid(0, 0), 16'd5);
    put(a_ccnt(1), 16'd1); put(a_chid(1, 0), 16'd3);
  endtask

  task automatic rand_scn;
    int nc, kc, c;
    clr_mem;
    nc = ($urandom_range(0, 7) == 0) ? int'($urandom_range(17, 24)) : int'($urandom_range(0, 5));
    if (nc > 16) kc = int'($urandom_range(1, 3));
    else kc = ($urandom_range(0, 9) == 0) ? int'($urandom_range(17, 20)) : int'($urandom_range(0, 4));
    put(NCNT, 16'(nc)); put(KCNT, 16'(kc));
    for (int j = 0; j < ((kc > 16) ? 16 : kc); j++) begin
      put(a_kch(j), 16'($urandom_range(1, 6)));
      put(a_hops(j), 16'($urandom_range(0, 30)));
    end
    for (int i = 0; i < ((nc > 16) ? 16 : nc); i++) begin
      c = int'($urandom_range(0, 9));
      put(a_ccnt(i), 16'(c));
      for (int k = 0; k < ((c > 8) ? 8 : c); k++) put(a_chid(i, k), 16'($urandom_range(1, 8)));
    end
  endtask

  initial begin
    int   cyc, nwr, ea, n;
    logic eo;
    rst = 1'b1; start = 1'b0; tb_we = 1'b0; tb_clr = 1'b0; tb_a = '0; tb_d = '0;
    repeat (2) @(posedge clock);
    #1;
    chk("reset_state0", {addr0, we0, dout0, busy0, done0, ovf0, app0}, 0);
    chk("reset_state1", {addr1, we1, dout1, busy1, done1, ovf1, app1}, 0);
    rst = 1'b0;

    // One missing entry in row1, hops=3: mode-1 seed 0x00D0.
    setup_t2(16'd3);
    ref_run(BIG, ea, eo);
    run(cyc, nwr);
    chk("t2_slot", mem0[a_chid(1, 1)], 16'd5);
    chk("t2_qv_m0", mem0[a_qv(1, 1)], 16'h0100);
    chk("t2_qv_m1", mem1[a_qv(1, 1)], 16'h00D0);
    chk("t2_ccnt", mem0[a_ccnt(1)], 16'd2);
    chk("t2_row0_ccnt", mem0[a_ccnt(0)], 16'd1);
    chk("t2_app", app0, 1);
    chk("t2_ovf", ovf0, 0);
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    chk("start_on_done_ignored", busy0, 0);
    verify(ea, eo, nwr);

    // hops=20 saturates the mode-1 seed at zero.
    setup_t2(16'd20);
    ref_run(BIG, ea, eo);
    run(cyc, nwr);
    chk("sat_qv_m1", mem1[a_qv(1, 1)], 16'h0000);
    verify(ea, eo, nwr);

    // Full row without the CH: overflow, no writes.
    clr_mem;
    put(NCNT, 16'd1); put(KCNT, 16'd1); put(a_kch(0), 16'd5); put(a_ccnt(0), 16'd8);
    for (int k = 0; k < 8; k++) put(a_chid(0, k), 16'(10 + k));
    ref_run(BIG, ea, eo);
    run(cyc, nwr);
    chk("full_ovf", ovf0, 1);
    chk("full_app", app0, 0);
    chk("full_writes", nwr, 0);
    verify(ea, eo, nwr);

    // ncnt=0: six cycles, no writes.
    clr_mem;
    put(KCNT, 16'd3);
    ref_run(BIG, ea, eo);
    run(cyc, nwr);
    chk("ncnt0_cycles", cyc, 6);
    chk("ncnt0_writes", nwr, 0);
    verify(ea, eo, nwr);

    // ncnt=20 clamps to 16.
    clr_mem;
    put(NCNT, 16'd20); put(KCNT, 16'd1); put(a_kch(0), 16'd4);
    ref_run(BIG, ea, eo);
    run(cyc, nwr);
    chk("clamp_ovf", ovf0, 1);
    chk("clamp_app", app0, 16);
    verify(ea, eo, nwr);

    // Known CHs {7,9}, three empty rows.
    clr_mem;
    put(NCNT, 16'd3); put(KCNT, 16'd2); put(a_kch(0), 16'd7); put(a_kch(1), 16'd9);
    ref_run(BIG, ea, eo);
    run(cyc, nwr);
    for (int i = 0; i < 3; i++) begin
      chk("empty_slot0", mem0[a_chid(i, 0)], 16'd7);
      chk("empty_slot1", mem0[a_chid(i, 1)], 16'd9);
      chk("empty_ccnt", mem0[a_ccnt(i)], 16'd2);
    end
    chk("empty_app", app0, 6);
    verify(ea, eo, nwr);

    // Reset during WR_QV, then clean rerun.
    setup_t2(16'd3);
    ref_run(1, ea, eo);
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    n = 0;
    while (we0 !== 1'b1 && n < 200) begin
      @(posedge clock); #1;
      n++;
    end
    chk("reach_write", n < 200, 1);
    @(posedge clock); #1;
    chk("in_wr_qv", we0, 1);
    rst = 1'b1;
    #1;
    chk("rst_wr_en", we0, 0);
    chk("rst_outs0", {addr0, we0, dout0, busy0, done0, ovf0, app0}, 0);
    chk("rst_outs1", {addr1, we1, dout1, busy1, done1, ovf1, app1}, 0);
    @(posedge clock); #1;
    rst = 1'b0;
    chk("partial_mem0", ndiff(1'b0), 0);
    chk("partial_mem1", ndiff(1'b1), 0);
    ref_run(BIG, ea, eo);
    run(cyc, nwr);
    chk("rerun_app", app0, 1);
    chk("rerun_ccnt", mem0[a_ccnt(1)], 16'd2);
    chk("no_dup", mem0[a_chid(1, 2)], 16'd0);
    verify(ea, eo, nwr);

    for (int t = 0; t < 25; t++) begin
      rand_scn;
      ref_run(BIG, ea, eo);
      run(cyc, nwr);
      verify(ea, eo, nwr);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
